// File: rtl/dnn_capture_logger_if.sv
// Capture/readback bus for dnn_capture_logger: control, sample input, read port and status.
// Master drives mode/skip/arm, the sample strobe and data, and the read address. It samples status and rd_data.
// Slave (the logger) drives rd_data and the status counters. There is no backpressure: every strobe is taken.
interface dnn_capture_logger_if #(
    parameter int DATA_W = 10,
    parameter int IDX_W  = 7,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic [1:0]              mode;
    logic [CNT_W-1:0]        skip;
    logic                    arm;
    logic                    sample_en;
    logic [DATA_W-1:0]       sample_data;
    logic [IDX_W-1:0]        cycle_index;
    logic                    rd_sel;
    logic [ADDR_W-1:0]       rd_addr;
    logic [IDX_W+DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]        sample_count;
    logic [ADDR_W:0]         store_count;
    logic [ADDR_W:0]         event_count;
    logic [DATA_W-1:0]       last_value;
    logic                    full;
    logic                    capturing;

    modport master (
        output mode, skip, arm, sample_en, sample_data, cycle_index, rd_sel, rd_addr,
        input  rd_data, sample_count, store_count, event_count, last_value, full, capturing
    );

    modport slave (
        input  mode, skip, arm, sample_en, sample_data, cycle_index, rd_sel, rd_addr,
        output rd_data, sample_count, store_count, event_count, last_value, full, capturing
    );
endinterface

// File: rtl/dnn_capture_logger.sv
// DNN output debug capture. It has a sample buffer with single-shot-after-skip, change-only or ring modes, and an event log of non-idle outputs.
// Latency: buffers are written on the strobe edge and status is visible the next cycle. rd_data is registered (1 cycle).
// Backpressure: none; the sample buffer stops at full (or wraps in ring mode) and the event log stops at DEPTH entries.
// Ports: clk, reset (async, active high), and bus (slave modport) carrying mode/skip/arm, sample_en/sample_data/cycle_index,
//        rd_sel/rd_addr -> rd_data, and status sample_count/store_count/event_count/last_value/full/capturing.
module dnn_capture_logger #(
    parameter int                DATA_W = 10,
    parameter int                IDX_W  = 7,
    parameter int                ADDR_W = 8,
    parameter int                CNT_W  = 16,
    parameter logic [DATA_W-1:0] IDLE_A = DATA_W'(1),
    parameter logic [DATA_W-1:0] IDLE_B = DATA_W'(0)
) (
    input  logic                clk,
    input  logic                reset,
    dnn_capture_logger_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_C = {1'b0, {ADDR_W{1'b1}}};

    localparam logic [1:0] M_SINGLE = 2'b00;
    localparam logic [1:0] M_CHANGE = 2'b01;
    localparam logic [1:0] M_RING   = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_STORE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [CNT_W-1:0]    skip_q, skip_d;
    logic [CNT_W-1:0]    skip_cnt_q, skip_cnt_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                first_q, first_d;
    logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
    logic [ADDR_W:0]     store_cnt_q, store_cnt_d;
    logic [ADDR_W:0]     ev_cnt_q, ev_cnt_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                full_q, full_d;
    logic                cap_q, cap_d;
    logic [IDX_W+DATA_W-1:0] rd_q;

    logic smp_we;
    logic ev_we;
    logic ev_hit;

    logic [DATA_W-1:0]       smp_mem [DEPTH];
    logic [IDX_W+DATA_W-1:0] ev_mem  [DEPTH];

    // Event log runs whenever armed. The MSB of ev_cnt_q marks the log full (no wrap). An arm in the same cycle drops the event.
    assign ev_hit = (state_q != S_IDLE) && !bus.arm && !ev_cnt_q[ADDR_W] &&
                    (bus.sample_data != IDLE_A) && (bus.sample_data != IDLE_B);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        skip_d      = skip_q;
        skip_cnt_d  = skip_cnt_q;
        ptr_d       = ptr_q;
        first_d     = first_q;
        smp_cnt_d   = smp_cnt_q;
        store_cnt_d = store_cnt_q;
        ev_cnt_d    = ev_cnt_q;
        last_d      = last_q;
        smp_we      = 1'b0;
        ev_we       = 1'b0;

        if (bus.sample_en) begin
            last_d = bus.sample_data;
        end

        if (ev_hit) begin
            ev_we    = 1'b1;
            ev_cnt_d = ev_cnt_q + (ADDR_W+1)'(1);
        end

        if (bus.arm) begin
            // Arm restarts everything. A coincident strobe is neither counted nor stored.
            mode_d      = (bus.mode == 2'b11) ? M_SINGLE : bus.mode;
            skip_d      = bus.skip;
            skip_cnt_d  = '0;
            ptr_d       = '0;
            first_d     = 1'b1;
            smp_cnt_d   = '0;
            store_cnt_d = '0;
            ev_cnt_d    = '0;
            state_d     = (mode_d == M_SINGLE && bus.skip != '0) ? S_SKIP : S_STORE;
        end else if (bus.sample_en) begin
            if (smp_cnt_q != '1) begin
                smp_cnt_d = smp_cnt_q + CNT_W'(1);
            end
            first_d = 1'b0;
            case (state_q)
                S_SKIP: begin
                    // The strobe that reaches the skip count is consumed, not stored.
                    skip_cnt_d = skip_cnt_q + CNT_W'(1);
                    if (skip_cnt_d == skip_q) begin
                        state_d = S_STORE;
                    end
                end
                S_STORE: begin
                    if (mode_q != M_CHANGE || first_q || bus.sample_data != last_q) begin
                        smp_we = 1'b1;
                        // The pointer wraps naturally; in the non-ring modes it tracks store_count.
                        ptr_d  = ptr_q + ADDR_W'(1);
                        if (!store_cnt_q[ADDR_W]) begin
                            store_cnt_d = store_cnt_q + (ADDR_W+1)'(1);
                        end
                        if (mode_q != M_RING && store_cnt_q == LAST_C) begin
                            state_d = S_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end

        full_d = store_cnt_d[ADDR_W] && (mode_d != M_RING);
        cap_d  = (state_d == S_SKIP) || (state_d == S_STORE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= M_SINGLE;
            skip_q      <= '0;
            skip_cnt_q  <= '0;
            ptr_q       <= '0;
            first_q     <= 1'b0;
            smp_cnt_q   <= '0;
            store_cnt_q <= '0;
            ev_cnt_q    <= '0;
            last_q      <= '0;
            full_q      <= 1'b0;
            cap_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            skip_q      <= skip_d;
            skip_cnt_q  <= skip_cnt_d;
            ptr_q       <= ptr_d;
            first_q     <= first_d;
            smp_cnt_q   <= smp_cnt_d;
            store_cnt_q <= store_cnt_d;
            ev_cnt_q    <= ev_cnt_d;
            last_q      <= last_d;
            full_q      <= full_d;
            cap_q       <= cap_d;
        end
    end

    // Buffer contents survive reset and arm. While reset is held the state is IDLE, so neither enable can fire.
    always_ff @(posedge clk) begin
        if (smp_we) begin
            smp_mem[ptr_q] <= bus.sample_data;
        end
        if (ev_we) begin
            ev_mem[ev_cnt_q[ADDR_W-1:0]] <= {bus.cycle_index, bus.sample_data};
        end
    end

    // Read-before-write: a same-address read in the write cycle returns the old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= bus.rd_sel ? ev_mem[bus.rd_addr] : {{IDX_W{1'b0}}, smp_mem[bus.rd_addr]};
        end
    end

    assign bus.rd_data      = rd_q;
    assign bus.sample_count = smp_cnt_q;
    assign bus.store_count  = store_cnt_q;
    assign bus.event_count  = ev_cnt_q;
    assign bus.last_value   = last_q;
    assign bus.full         = full_q;
    assign bus.capturing    = cap_q;
endmodule

// File: tb/tb_dnn_capture_logger.sv
// Bench for dnn_capture_logger. Two instances (DEPTH 256 and DEPTH 4) share one stimulus stream.
// A directed vector table exercises the capture scenarios. Random cycles then follow.
// A buffer-level reference model checks every output of both instances each cycle.
module tb_dnn_capture_logger;
    localparam int C_NONE = 0, C_RD = 1, C_STC = 2, C_SMC = 3, C_LV = 4, C_EVC = 5, C_FULL = 6, C_CAP = 7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0, sample_en = 1'b0, rd_sel = 1'b0;
    logic [1:0]  mode = '0;
    logic [15:0] skip = '0;
    logic [9:0]  sample_data = '0;
    logic [6:0]  cycle_index = '0;
    logic [7:0]  rd_addr = '0;

    dnn_capture_logger_if #(.DATA_W(10), .IDX_W(7), .ADDR_W(8), .CNT_W(16)) ifa ();
    dnn_capture_logger_if #(.DATA_W(10), .IDX_W(7), .ADDR_W(2), .CNT_W(16)) ifb ();

    assign ifa.mode = mode;           assign ifb.mode = mode;
    assign ifa.skip = skip;           assign ifb.skip = skip;
    assign ifa.arm = arm;             assign ifb.arm = arm;
    assign ifa.sample_en = sample_en; assign ifb.sample_en = sample_en;
    assign ifa.sample_data = sample_data; assign ifb.sample_data = sample_data;
    assign ifa.cycle_index = cycle_index; assign ifb.cycle_index = cycle_index;
    assign ifa.rd_sel = rd_sel;       assign ifb.rd_sel = rd_sel;
    assign ifa.rd_addr = rd_addr;     assign ifb.rd_addr = rd_addr[1:0];

    dnn_capture_logger #(.DATA_W(10), .IDX_W(7), .ADDR_W(8), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    dnn_capture_logger #(.DATA_W(10), .IDX_W(7), .ADDR_W(2), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    string sn [8] = '{"none", "rd_data", "store_count", "sample_count", "last_value", "event_count", "full", "capturing"};

    // Reference model: per-instance capture bookkeeping plus memory images with written flags.
    int  depth [2] = '{256, 4};
    bit  m_armed [2];
    int  m_mode [2], m_skip [2], m_n [2], m_stored [2], m_sc [2], m_last [2], m_ev [2];
    int  m_smem [2][256];
    bit  m_sval [2][256];
    int  m_emem [2][256];
    bit  m_eval [2][256];
    int  m_rd [2];
    bit  m_rdk [2];

    typedef struct {
        bit r; bit a; int md; int sk; bit e; int d; int ix; bit rs; int ra;
        int ci; int cs; int ex; string nm;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit m_done(input int k);
        return m_armed[k] && m_mode[k] != 2 && m_stored[k] >= depth[k];
    endfunction

    task automatic model_step(input int k, input vec_t v);
        int  addr;
        bit  st;
        if (v.r) begin
            m_armed[k] = 0; m_mode[k] = 0; m_skip[k] = 0; m_n[k] = 0; m_stored[k] = 0;
            m_sc[k] = 0; m_last[k] = 0; m_ev[k] = 0; m_rd[k] = 0; m_rdk[k] = 1;
            return;
        end
        addr = v.ra % depth[k];
        m_rdk[k] = v.rs ? m_eval[k][addr] : m_sval[k][addr];
        m_rd[k]  = v.rs ? m_emem[k][addr] : m_smem[k][addr];
        if (!v.a && m_armed[k] && v.d != 0 && v.d != 1 && m_ev[k] < depth[k]) begin
            m_emem[k][m_ev[k]] = v.ix * 1024 + v.d;
            m_eval[k][m_ev[k]] = 1;
            m_ev[k]++;
        end
        if (v.a) begin
            m_armed[k] = 1; m_mode[k] = (v.md == 3) ? 0 : v.md; m_skip[k] = v.sk;
            m_n[k] = 0; m_stored[k] = 0; m_sc[k] = 0; m_ev[k] = 0;
        end else if (v.e) begin
            if (m_sc[k] < 65535) m_sc[k]++;
            if (m_armed[k] && !m_done(k)) begin
                m_n[k]++;
                case (m_mode[k])
                    0:       st = m_n[k] > m_skip[k];
                    1:       st = (m_n[k] == 1) || (v.d != m_last[k]);
                    default: st = 1;
                endcase
                if (st) begin
                    m_smem[k][m_stored[k] % depth[k]] = v.d;
                    m_sval[k][m_stored[k] % depth[k]] = 1;
                    m_stored[k]++;
                end
            end
        end
        if (v.e) m_last[k] = v.d;
    endtask

    function automatic int exp_out(input int k, input int sel);
        case (sel)
            C_RD:    return m_rd[k];
            C_STC:   return (m_stored[k] < depth[k]) ? m_stored[k] : depth[k];
            C_SMC:   return m_sc[k];
            C_LV:    return m_last[k];
            C_EVC:   return m_ev[k];
            C_FULL:  return int'(m_done(k));
            default: return int'(m_armed[k] && !m_done(k));
        endcase
    endfunction

    function automatic int out_of(input int k, input int sel);
        case (sel)
            C_RD:    return (k == 0) ? int'(ifa.rd_data)      : int'(ifb.rd_data);
            C_STC:   return (k == 0) ? int'(ifa.store_count)  : int'(ifb.store_count);
            C_SMC:   return (k == 0) ? int'(ifa.sample_count) : int'(ifb.sample_count);
            C_LV:    return (k == 0) ? int'(ifa.last_value)   : int'(ifb.last_value);
            C_EVC:   return (k == 0) ? int'(ifa.event_count)  : int'(ifb.event_count);
            C_FULL:  return (k == 0) ? int'(ifa.full)         : int'(ifb.full);
            default: return (k == 0) ? int'(ifa.capturing)    : int'(ifb.capturing);
        endcase
    endfunction

    // Drives one cycle's inputs after a falling edge and lets the rising edge happen.
    // At the next falling edge it compares both instances with the model, then applies the vector's own check.
    task automatic cycle(input vec_t v);
        reset = v.r; arm = v.a; mode = 2'(v.md); skip = 16'(v.sk); sample_en = v.e;
        sample_data = 10'(v.d); cycle_index = 7'(v.ix); rd_sel = v.rs; rd_addr = 8'(v.ra);
        for (int k = 0; k < 2; k++) model_step(k, v);
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            for (int s = C_RD; s <= C_CAP; s++)
                if (s != C_RD || m_rdk[k])
                    chk($sformatf("model dut%0d %s", k, sn[s]), out_of(k, s), exp_out(k, s));
        if (v.cs != C_NONE)
            chk(v.nm, out_of(v.ci, v.cs), v.ex);
    endtask

    task automatic add(input bit r, input bit a, input int md, input int sk, input bit e, input int d,
                       input int ix, input bit rs, input int ra, input int ci, input int cs, input int ex,
                       input string nm);
        vec_t v;
        v.r = r; v.a = a; v.md = md; v.sk = sk; v.e = e; v.d = d; v.ix = ix; v.rs = rs; v.ra = ra;
        v.ci = ci; v.cs = cs; v.ex = ex; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic stb(input int d, input int ci = 0, input int cs = C_NONE, input int ex = 0, input string nm = "");
        add(0, 0, 0, 0, 1, d, d % 128, 0, 0, ci, cs, ex, nm);
    endtask
    task automatic armv(input int md, input int sk, input int ci = 0, input int cs = C_NONE, input int ex = 0,
                        input string nm = "");
        add(0, 1, md, sk, 0, 0, 0, 0, 0, ci, cs, ex, nm);
    endtask
    task automatic rdv(input int ci, input bit rs, input int ra, input int ex, input string nm);
        add(0, 0, 0, 0, 0, 0, 0, rs, ra, ci, C_RD, ex, nm);
    endtask
    task automatic obs(input int ci, input int cs, input int ex, input string nm);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, ci, cs, ex, nm);
    endtask

    initial begin
        vec_t rv;
        // Reset state
        for (int s = C_RD; s <= C_CAP; s++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, 0, {"reset ", sn[s]});
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, "");
        // Single-shot with skip=3: strobes 1..10, buffer gets 4..10
        armv(0, 3, 0, C_CAP, 1, "skip cap_after_arm");
        for (int i = 1; i <= 10; i++) stb(i);
        for (int i = 0; i < 7; i++) rdv(0, 0, i, 4 + i, $sformatf("skip rd[%0d]", i));
        obs(0, C_STC, 7, "skip store_count");
        obs(0, C_SMC, 10, "skip sample_count");
        obs(0, C_CAP, 1, "skip capturing");
        // Change-only
        armv(1, 0);
        stb(5); stb(5); stb(5); stb(7); stb(7); stb(2);
        rdv(0, 0, 0, 5, "chg rd0"); rdv(0, 0, 1, 7, "chg rd1"); rdv(0, 0, 2, 2, "chg rd2");
        obs(0, C_STC, 3, "chg store_count");
        obs(0, C_LV, 2, "chg last_value");
        // Ring on the DEPTH-4 instance
        armv(2, 0);
        for (int i = 1; i <= 6; i++) stb(i);
        rdv(1, 0, 0, 5, "ring rd0"); rdv(1, 0, 1, 6, "ring rd1");
        rdv(1, 0, 2, 3, "ring rd2"); rdv(1, 0, 3, 4, "ring rd3");
        obs(1, C_STC, 4, "ring store_count");
        obs(1, C_FULL, 0, "ring full");
        // Full / DONE on the DEPTH-4 instance, then re-arm
        armv(0, 0);
        stb(11); stb(12); stb(13); stb(14, 1, C_FULL, 1, "done full");
        stb(15, 1, C_CAP, 0, "done capturing");
        stb(16);
        for (int i = 0; i < 4; i++) rdv(1, 0, i, 11 + i, $sformatf("done rd[%0d]", i));
        obs(1, C_STC, 4, "done store_count");
        obs(1, C_SMC, 6, "done sample_count");
        armv(0, 0, 1, C_SMC, 0, "rearm sample_count");
        obs(1, C_STC, 0, "rearm store_count");
        obs(1, C_FULL, 0, "rearm full");
        obs(1, C_CAP, 1, "rearm capturing");
        stb(20);
        rdv(1, 0, 0, 20, "rearm rd0");
        obs(1, C_STC, 1, "rearm store_count1");
        // Event log
        armv(0, 0);
        add(0, 0, 0, 0, 0, 0, 10, 0, 0, 0, C_NONE, 0, "");
        add(0, 0, 0, 0, 0, 1, 11, 0, 0, 0, C_NONE, 0, "");
        add(0, 0, 0, 0, 0, 9, 12, 0, 0, 0, C_NONE, 0, "");
        add(0, 0, 0, 0, 0, 1, 13, 0, 0, 0, C_NONE, 0, "");
        add(0, 0, 0, 0, 0, 3, 14, 0, 0, 0, C_NONE, 0, "");
        obs(0, C_EVC, 2, "event count");
        rdv(0, 1, 0, 12 * 1024 + 9, "event rd0");
        rdv(0, 1, 1, 14 * 1024 + 3, "event rd1");
        // Arm colliding with a strobe, then reset mid-STORE
        add(0, 1, 0, 0, 1, 8, 0, 0, 0, 0, C_SMC, 0, "collide sample_count");
        obs(0, C_STC, 0, "collide store_count");
        obs(0, C_LV, 8, "collide last_value");
        obs(0, C_EVC, 0, "collide event_count");
        stb(3); stb(4, 0, C_STC, 2, "pre-reset store_count");
        for (int s = C_RD; s <= C_CAP; s++) add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, s, 0, {"midreset ", sn[s]});
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 0, "");

        foreach (tbl[i]) cycle(tbl[i]);

        // Random phase: frequent re-arms and resets first, then long captures that fill, wrap and saturate the logs.
        for (int i = 0; i < 4000; i++) begin
            rv.r  = (i < 2000) && ($urandom_range(299) == 0);
            rv.a  = (i < 2000) ? ($urandom_range(24) == 0) : ($urandom_range(699) == 0);
            rv.md = $urandom_range(3);
            rv.sk = $urandom_range(5);
            rv.e  = ($urandom_range(3) != 0);
            rv.d  = ($urandom_range(3) == 0) ? $urandom_range(1023) : $urandom_range(7);
            rv.ix = $urandom_range(127);
            rv.rs = $urandom_range(1);
            rv.ra = $urandom_range(255);
            rv.ci = 0; rv.cs = C_NONE; rv.ex = 0; rv.nm = "";
            cycle(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
